// File: rtl/fifo_rd_stream.sv
// Read side of an async FIFO with a registered valid/ready output stage.
// Optional almost-empty flag is built only when FIFO_RD_ALMOST_EMPTY_EN is defined.
module fifo_rd_stream #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic                arempty
`endif
);

  // The threshold is compared against a pointer-width occupancy, so it must fit.
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDRSIZE)) begin : g_bad_thresh
    $error("AEMPTY_THRESH out of range for ADDRSIZE");
  end

  logic [ADDRSIZE:0] r_rbin;
  logic              w_pop;
  logic [ADDRSIZE:0] w_rbin_next;
  logic [ADDRSIZE:0] w_rgray_next;

  assign w_pop        = !rempty && (!m_valid || m_ready);
  assign w_rbin_next  = r_rbin + {{ADDRSIZE{1'b0}}, w_pop};
  assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
  assign raddr        = r_rbin[ADDRSIZE-1:0];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      r_rbin <= w_rbin_next;
      rptr   <= w_rgray_next;
      rempty <= (w_rgray_next == rq2_wptr);
    end
  end

  // Output stage: a pop refills the slot on the same edge it is consumed.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (w_pop) begin
      m_valid <= 1'b1;
      m_data  <= rdata;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [ADDRSIZE:0] LP_AE_THRESH = AEMPTY_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_occupancy;

  always_comb begin
    w_wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      w_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign w_occupancy = w_wbin - w_rbin_next;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      arempty <= 1'b1;
    end else begin
      arempty <= (w_occupancy <= LP_AE_THRESH);
    end
  end
`endif

endmodule
